// File: rtl/stream_packer.sv
// stream_packer: packs RATIO narrow beats of DATA_WIDTH bits into one wide word.
// The first accepted beat of a word lands in lane 0 (least significant bits).
// The wide word is registered; the last beat of a word is accepted on the same
// edge that the previous word drains, so full throughput needs no bubbles.
//
// Ports:
//   clk_i           clock, rising edge
//   arst_n          asynchronous active-low reset
//   data_in         narrow beat              (valid/ready handshake)
//   data_in_valid   narrow beat present
//   data_in_ready   narrow beat accepted this cycle
//   data_out        packed wide word         (valid/ready handshake)
//   data_out_valid  wide word present
//   data_out_ready  downstream accepts the wide word
//   flush_i         request emission of a partial word     (STREAM_PACKER_FLUSH_EN only)
//   data_out_lanes  number of valid lanes in data_out      (STREAM_PACKER_FLUSH_EN only)
//
// Optional feature: define STREAM_PACKER_FLUSH_EN to add the flush function.

module stream_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4
) (
    input  logic                          clk_i,
    input  logic                          arst_n,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic [DATA_WIDTH*RATIO-1:0]   data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready
`ifdef STREAM_PACKER_FLUSH_EN
    ,
    input  logic                          flush_i,
    output logic [$clog2(RATIO+1)-1:0]    data_out_lanes
`endif
);

    localparam int unsigned CntW   = $clog2(RATIO);
    localparam int unsigned AccW   = DATA_WIDTH * (RATIO - 1);
    localparam int unsigned WordW  = DATA_WIDTH * RATIO;
    localparam logic [CntW-1:0] LastCnt = CntW'(RATIO - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [WordW-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic last_lane;
    logic out_free;
    logic accept;

    assign last_lane = (cnt_q == LastCnt);
    assign out_free  = !out_valid_q || data_out_ready;

`ifdef STREAM_PACKER_FLUSH_EN
    localparam int unsigned LanesW = $clog2(RATIO + 1);

    logic              flush_q, flush_d;
    logic [LanesW-1:0] lanes_q, lanes_d;
    logic [WordW-1:0]  acc_ext;
    logic [WordW-1:0]  pack_word;

    // While a flush waits for the output register, no beat may be taken: it
    // would have to join the partial word, which has nowhere to go yet.
    assign data_in_ready = out_free || (!last_lane && !flush_q);

    assign acc_ext = {{DATA_WIDTH{1'b0}}, acc_q};

    // Partial word: lanes below cnt from the accumulator, lane cnt from the
    // beat accepted this cycle (if any), everything above zeroed.
    always_comb begin
        pack_word = '0;
        for (int k = 0; k < int'(RATIO); k++) begin
            if (CntW'(k) < cnt_q) begin
                pack_word[k*DATA_WIDTH +: DATA_WIDTH] = acc_ext[k*DATA_WIDTH +: DATA_WIDTH];
            end else if ((CntW'(k) == cnt_q) && accept) begin
                pack_word[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end
        end
    end
`else
    assign data_in_ready = !last_lane || out_free;
`endif

    assign accept = data_in_valid && data_in_ready;

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_d       = out_q;
        // A drain clears valid; a reload below sets it again on the same edge.
        out_valid_d = out_valid_q && !data_out_ready;

        if (accept) begin
            if (last_lane) begin
                out_d       = {data_in, acc_q};
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                for (int k = 0; k < int'(RATIO) - 1; k++) begin
                    if (cnt_q == CntW'(k)) begin
                        acc_d[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end

`ifdef STREAM_PACKER_FLUSH_EN
        flush_d = flush_q || flush_i;
        lanes_d = lanes_q;
        if (accept && last_lane) begin
            lanes_d = LanesW'(RATIO);
        end

        if (flush_q) begin
            if (accept) begin
                // Beat joins the partial word; out_free is implied by accept.
                out_d       = pack_word;
                out_valid_d = 1'b1;
                lanes_d     = LanesW'(cnt_q) + 1'b1;
                cnt_d       = '0;
                flush_d     = flush_i;
            end else if (cnt_q == '0) begin
                // Nothing buffered: the flush is dropped.
                flush_d = flush_i;
            end else if (out_free) begin
                out_d       = pack_word;
                out_valid_d = 1'b1;
                lanes_d     = LanesW'(cnt_q);
                cnt_d       = '0;
                flush_d     = flush_i;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
            flush_q     <= 1'b0;
            lanes_q     <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef STREAM_PACKER_FLUSH_EN
            flush_q     <= flush_d;
            lanes_q     <= lanes_d;
`endif
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;
`ifdef STREAM_PACKER_FLUSH_EN
    assign data_out_lanes = lanes_q;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (DATA_WIDTH=8, RATIO=4).
// A monitor samples both handshakes on the falling edge; accepted input beats
// are packed in order into expected words, which are popped and compared when
// the DUT hands a word downstream. Scenario tasks add direct checks.

module tb_stream_packer;

    localparam int DW = 8;
    localparam int R  = 4;

    logic            clk_i = 1'b0;
    logic            arst_n = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic            data_in_valid = 1'b0;
    logic            data_in_ready;
    logic [DW*R-1:0] data_out;
    logic            data_out_valid;
    logic            data_out_ready = 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
    logic            flush_i = 1'b0;
    logic [2:0]      data_out_lanes;
`endif

    stream_packer #(
        .DATA_WIDTH (DW),
        .RATIO      (R)
    ) dut (
        .clk_i          (clk_i),
        .arst_n         (arst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
`ifdef STREAM_PACKER_FLUSH_EN
        ,
        .flush_i        (flush_i),
        .data_out_lanes (data_out_lanes)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [DW*R-1:0] exp_q[$];
    logic [DW-1:0]   part_q[$];
    logic [DW*R-1:0] mon_w;
    logic [DW*R-1:0] mon_exp;
    int              beats_in = 0;
    int              words_out = 0;
    bit              sb_en = 1'b0;

    // Scoreboard monitor: outputs are compared before the same-cycle input is
    // folded into the model, matching the order words leave the DUT.
    always @(negedge clk_i) begin
        if (arst_n && sb_en) begin
            if (data_out_valid && data_out_ready) begin
                checks++;
                words_out++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_word: got unexpected word %h, none expected", data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (data_out !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_word: got %h expected %h", data_out, mon_exp);
                    end
                end
            end
            if (data_in_valid && data_in_ready) begin
                beats_in++;
                part_q.push_back(data_in);
                if (part_q.size() == R) begin
                    for (int i = 0; i < R; i++) mon_w[i*DW +: DW] = part_q[i];
                    exp_q.push_back(mon_w);
                    part_q.delete();
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #3;
        checks++;
        if (data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", data_in_ready);
        end
        checks++;
        if (data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", data_out_valid);
        end
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", data_out);
        end
`ifdef STREAM_PACKER_FLUSH_EN
        checks++;
        if (data_out_lanes !== 3'd0) begin
            errors++;
            $display("FAIL reset_lanes: got %0d expected 0", data_out_lanes);
        end
`endif
        step();
        step();
        arst_n = 1'b1;
        sb_en  = 1'b1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] beats [R];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        data_out_ready = 1'b1;
        for (int i = 0; i < R; i++) begin
            data_in       = beats[i];
            data_in_valid = 1'b1;
            step();
            if (i < R - 1) begin
                checks++;
                if (data_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid: beat %0d got %b expected 0", i, data_out_valid);
                end
            end
        end
        data_in_valid = 1'b0;
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== 32'h44332211) begin
            errors++;
            $display("FAIL basic_word: got valid=%b data=%h expected valid=1 data=44332211",
                     data_out_valid, data_out);
        end
        step();
        checks++;
        if (data_out_valid !== 1'b0 || data_out !== 32'h44332211) begin
            errors++;
            $display("FAIL basic_drain: got valid=%b data=%h expected valid=0 data=44332211",
                     data_out_valid, data_out);
        end
    endtask

    task automatic test_backpressure();
        data_out_ready = 1'b0;
        for (int i = 0; i < R; i++) begin
            data_in       = 8'hA1 + 8'(i);
            data_in_valid = 1'b1;
            step();
        end
        for (int i = 0; i < R - 1; i++) begin
            data_in = 8'hB1 + 8'(i);
            step();
            checks++;
            if (data_out_valid !== 1'b1 || data_out !== 32'hA4A3A2A1) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=a4a3a2a1",
                         data_out_valid, data_out);
            end
        end
        data_in = 8'hB4;
        #1;
        checks++;
        if (data_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: got %b expected 0", data_in_ready);
        end
        step();
        checks++;
        if (data_in_ready !== 1'b0 || data_out !== 32'hA4A3A2A1) begin
            errors++;
            $display("FAIL bp_stall: got ready=%b data=%h expected ready=0 data=a4a3a2a1",
                     data_in_ready, data_out);
        end
        data_out_ready = 1'b1;
        #1;
        checks++;
        if (data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb: got %b expected 1", data_in_ready);
        end
        step();
        data_in_valid = 1'b0;
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== 32'hB4B3B2B1) begin
            errors++;
            $display("FAIL bp_reload: got valid=%b data=%h expected valid=1 data=b4b3b2b1",
                     data_out_valid, data_out);
        end
        step();
        checks++;
        if (data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %b expected 0", data_out_valid);
        end
    endtask

    task automatic test_mid_reset();
        data_out_ready = 1'b1;
        data_in_valid  = 1'b1;
        data_in = 8'hAA;
        step();
        data_in = 8'hBB;
        step();
        data_in_valid = 1'b0;
        #2;
        arst_n = 1'b0;
        part_q.delete();
        exp_q.delete();
        #1;
        checks++;
        if (data_out !== '0 || data_out_valid !== 1'b0 || data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got data=%h valid=%b ready=%b expected 0/0/1",
                     data_out, data_out_valid, data_in_ready);
        end
        step();
        arst_n = 1'b1;
        for (int i = 0; i < R; i++) begin
            data_in       = 8'h01 + 8'(i);
            data_in_valid = 1'b1;
            step();
        end
        data_in_valid = 1'b0;
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== 32'h04030201) begin
            errors++;
            $display("FAIL mid_reset_word: got valid=%b data=%h expected valid=1 data=04030201",
                     data_out_valid, data_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int words_start;
        words_start    = words_out;
        data_out_ready = 1'b1;
        data_in_valid  = 1'b1;
        for (int i = 0; i < 3 * R; i++) begin
            data_in = 8'h30 + 8'(i);
            #1;
            checks++;
            if (data_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: beat %0d got %b expected 1", i, data_in_ready);
            end
            step();
        end
        data_in_valid = 1'b0;
        step();
        step();
        checks++;
        if (words_out - words_start !== 3) begin
            errors++;
            $display("FAIL b2b_words: got %0d expected 3", words_out - words_start);
        end
    endtask

    task automatic test_random();
        int drain_cycles;
        beats_in  = 0;
        words_out = 0;
        for (int c = 0; c < 200; c++) begin
            data_in        = 8'($urandom());
            data_in_valid  = ($urandom_range(0, 1) == 1);
            data_out_ready = ($urandom_range(0, 99) < 17);
            step();
        end
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        drain_cycles   = 0;
        while ((exp_q.size() != 0 || data_out_valid) && drain_cycles < 50) begin
            step();
            drain_cycles++;
        end
        step();
        checks++;
        if (exp_q.size() != 0 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got %0d words pending valid=%b expected 0 and 0",
                     exp_q.size(), data_out_valid);
        end
        checks++;
        if (words_out != beats_in / R) begin
            errors++;
            $display("FAIL rand_count: got %0d words expected %0d (beats %0d)",
                     words_out, beats_in / R, beats_in);
        end
    endtask

`ifdef STREAM_PACKER_FLUSH_EN
    task automatic test_flush();
        bit got;
        sb_en  = 1'b0;
        #2;
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        data_out_ready = 1'b1;
        data_in_valid  = 1'b1;
        data_in = 8'hAA;
        step();
        data_in = 8'hBB;
        step();
        data_in_valid = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            if (data_out_valid === 1'b1) got = 1'b1;
            else step();
        end
        checks++;
        if (!got || data_out !== 32'h0000BBAA || data_out_lanes !== 3'd2) begin
            errors++;
            $display("FAIL flush_word: got seen=%b data=%h lanes=%0d expected 1/0000bbaa/2",
                     got, data_out, data_out_lanes);
        end
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (data_out_valid === 1'b1) got = 1'b1;
            step();
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL flush_empty: got an output word, expected none");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef STREAM_PACKER_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one narrow input beat.
REQ-002 Parameter RATIO, default 4: narrow beats per wide output word; legal range >= 2.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  DATA_WIDTH  narrow beat from upstream source.
REQ-006 data_in_valid  input  1  narrow beat present.
REQ-007 data_in_ready  output  1  block accepts the narrow beat this cycle.
REQ-008 data_out  output  DATA_WIDTH*RATIO  packed wide word, fed to the downstream pipeline.
REQ-009 data_out_valid  output  1  wide word present.
REQ-010 data_out_ready  input  1  downstream pipeline accepts the wide word.
REQ-011 flush_i  input  1  request to emit a partial word (present only with STREAM_PACKER_FLUSH_EN).
REQ-012 data_out_lanes  output  $clog2(RATIO+1)  count of valid lanes in data_out (present only with STREAM_PACKER_FLUSH_EN).

Function
REQ-013 A transfer occurs on an input or output port only on a rising edge where valid and ready are both 1.
REQ-014 Lane counter cnt (0..RATIO-1) gives the lane index of the next accepted beat; the first beat of a word lands in lane 0 (bits DATA_WIDTH-1:0), and lane k occupies bits (k+1)*DATA_WIDTH-1 : k*DATA_WIDTH.
REQ-015 An accepted beat with cnt < RATIO-1 is stored in accumulator lane cnt, and cnt increments.
REQ-016 An accepted beat with cnt == RATIO-1 loads {data_in, accumulator lanes RATIO-2..0} into the output register on the same edge, sets data_out_valid, and wraps cnt to 0.
REQ-017 Latency: data_out_valid rises on the edge that accepts the last lane, so it is visible one cycle after that beat is presented.
REQ-018 Output register is free when data_out_valid == 0 or data_out_ready == 1.
REQ-019 data_in_ready = (cnt != RATIO-1) || output register free; the only combinational path from data_out_ready to data_in_ready is therefore the cnt == RATIO-1 case.
REQ-020 A simultaneous output drain and last-lane accept on the same edge reloads the output register, and data_out_valid stays 1.
REQ-021 An output drain with no reload clears data_out_valid, and data_out holds its last value.
REQ-022 data_out and data_out_valid remain stable while data_out_valid == 1 and data_out_ready == 0.
REQ-023 Sustained throughput with data_out_ready held at 1 is one wide word per RATIO cycles, with no bubbles.

Reset
REQ-024 While arst_n == 0: cnt = 0, accumulator = 0, data_out = 0, data_out_valid = 0, data_out_lanes = 0, pending flush = 0, and data_in_ready = 1.
REQ-025 Reset mid-word discards all partially accumulated lanes; the first beat after release lands in lane 0.

Configuration
REQ-026 Macro STREAM_PACKER_FLUSH_EN, when defined, adds flush_i and data_out_lanes and the flush function described in REQ-027 to REQ-031.
REQ-027 A flush_i sample of 1 sets a pending-flush flag; the flag stays set until the flush is serviced.
REQ-028 A pending flush with cnt > 0 and a free output register loads the accumulator, with lanes >= cnt set to 0, into the output register, sets data_out_lanes = cnt, and clears cnt and the flag.
REQ-029 A flush coincident with an accepted beat includes that beat first, so the emitted word carries cnt+1 lanes, or RATIO lanes if the beat completes the word; the flag clears.
REQ-030 A pending flush with cnt == 0 and no beat accepted is discarded with no output.
REQ-031 data_in_ready = 0 while a flush is pending and the output register is not free.
REQ-032 Without STREAM_PACKER_FLUSH_EN: flush_i and data_out_lanes do not exist, and every emitted word contains exactly RATIO lanes.

Verification
REQ-033 Basic packing (RATIO=4, DATA_WIDTH=8, data_out_ready=1): beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> data_out = 0x44332211 with data_out_valid high for exactly 1 cycle.
REQ-034 Backpressure: one word held with data_out_ready=0 and cnt=3 -> data_in_ready=0; raise data_out_ready -> the held word drains and the 4th beat is accepted on the same edge.
REQ-035 Mid-word reset: beats 0xAA, 0xBB, then an arst_n pulse, then beats 0x01 to 0x04 -> single output word 0x04030201, with no trace of 0xAA or 0xBB.
REQ-036 Flush (FLUSH_EN): beats 0xAA, 0xBB, then a flush_i pulse -> data_out = 0x0000BBAA and data_out_lanes = 2; a flush_i pulse with cnt=0 produces no output.
REQ-037 Random traffic: 200 cycles, data_in_valid at 50%, data_out_ready at 17%, then data_out_ready=1 until drained -> a scoreboard packing input beats in order reports 0 mismatches, and the final count of words out equals floor(beats in / 4).
